// File: rtl/pb_hub_pkg.sv
// Register map offsets and shared helpers for the PicoBlaze port hub.
package pb_hub_pkg;

    localparam logic [4:0] OFS_OUT       = 5'h00;
    localparam logic [4:0] OFS_IN        = 5'h10;
    localparam logic [4:0] OFS_BTN_LEVEL = 5'h18;
    localparam logic [4:0] OFS_BTN_EDGE  = 5'h19;
    localparam logic [4:0] OFS_IRQ_MASK  = 5'h1A;
    localparam logic [4:0] OFS_IRQ_PEND  = 5'h1B;
    localparam logic [4:0] OFS_RAM_ADDR  = 5'h1C;
    localparam logic [4:0] OFS_RAM_DATA  = 5'h1D;
    localparam logic [4:0] OFS_RAM_CTRL  = 5'h1E;
    localparam logic [4:0] OFS_IRQ_ID    = 5'h1F;

    localparam logic [7:0] IRQ_ID_NONE   = 8'hFF;

    // Index of the lowest set bit, or IRQ_ID_NONE when no bit is set.
    function automatic logic [7:0] lowest_set_idx(input logic [7:0] vec);
        logic [7:0] idx;
        idx = IRQ_ID_NONE;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 8'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pb_port_hub_if.sv
// KCPSM6 port bus: processor side is the master, the hub is the slave.
interface pb_port_hub_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic       interrupt_ack;
    logic [7:0] in_port;
    logic       interrupt;

    modport master (
        output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
        output in_port, interrupt
    );
endinterface

// File: rtl/pb_debounce.sv
// One button: 2-flop synchroniser, stability counter and debounced level.
// rise pulses in the cycle before level goes 0->1.
module pb_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic pclk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise
);
    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q, level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          toggle_s;

    // Count consecutive cycles the synced input disagrees with the level.
    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        toggle_s = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d    = {CW{1'b0}};
                level_d  = ~level_q;
                toggle_s = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Synchroniser, counter and level registers.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = toggle_s & ~level_q;
endmodule

// File: rtl/pb_port_hub.sv
// KCPSM6 peripheral hub: output/input ports, debounced buttons, RAM window
// with auto-increment pointer and a masked, prioritised interrupt aggregator.
module pb_port_hub
    import pb_hub_pkg::*;
#(
    parameter logic [7:0] BASE      = 8'h20,
    parameter int         NUM_OUT   = 4,
    parameter int         NUM_IN    = 2,
    parameter int         NUM_BTN   = 5,
    parameter int         DB_CYCLES = 16,
    parameter int         NUM_IRQ   = 4,
    parameter int         RAM_AW    = 8
) (
    input  logic                   pclk,
    input  logic                   reset,
    pb_port_hub_if.slave           bus,
    output logic [NUM_OUT*8-1:0]   out_regs,
    input  logic [NUM_IN*8-1:0]    in_regs,
    input  logic [NUM_BTN-1:0]     btn_raw,
    input  logic [NUM_IRQ-1:0]     irq_src
);
    localparam int         RAM_DEPTH = 1 << RAM_AW;
    localparam logic [7:0] IRQ_VALID = 8'((9'd1 << NUM_IRQ) - 9'd1);

    logic              hit_s, wr_s, rd_s;
    logic [4:0]        ofs_s;
    logic [7:0]        out_q [NUM_OUT];
    logic [7:0]        out_d [NUM_OUT];
    logic [NUM_BTN-1:0] btn_level_s, btn_rise_s, btn_edge_q, btn_edge_d;
    logic [7:0]        irq_prev_q, irq_pend_q, irq_pend_d, irq_mask_q, irq_mask_d;
    logic [7:0]        irq_id_q, irq_id_d, irq_masked_s, ack_idx_s, clr_w1c_s, clr_ack_s;
    logic              interrupt_q, interrupt_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic              ram_ctrl_q, ram_ctrl_d;
    logic [7:0]        mem_q [RAM_DEPTH];
    logic [7:0]        rdata_s;

    assign hit_s        = (bus.port_id[7:5] == BASE[7:5]);
    assign ofs_s        = bus.port_id[4:0];
    assign wr_s         = bus.write_strobe & hit_s;
    assign rd_s         = bus.read_strobe & hit_s;
    assign irq_masked_s = irq_pend_q & irq_mask_q;
    assign ack_idx_s    = lowest_set_idx(irq_masked_s);

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign out_regs[8*g +: 8] = out_q[g];
    end

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .pclk    (pclk),
            .reset   (reset),
            .btn_raw (btn_raw[b]),
            .level   (btn_level_s[b]),
            .rise    (btn_rise_s[b])
        );
    end

    // Next state of output registers, button edges, IRQ and RAM pointer.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            if (wr_s && (ofs_s < OFS_IN) && (ofs_s[3:0] == 4'(k))) begin
                out_d[k] = bus.out_port;
            end else begin
                out_d[k] = out_q[k];
            end
        end

        // A rising level in the same cycle as the clearing read survives.
        if (rd_s && (ofs_s == OFS_BTN_EDGE)) begin
            btn_edge_d = btn_rise_s;
        end else begin
            btn_edge_d = btn_edge_q | btn_rise_s;
        end

        if (wr_s && (ofs_s == OFS_IRQ_MASK)) begin
            irq_mask_d = bus.out_port & IRQ_VALID;
        end else begin
            irq_mask_d = irq_mask_q;
        end

        if (wr_s && (ofs_s == OFS_IRQ_PEND)) begin
            clr_w1c_s = bus.out_port;
        end else begin
            clr_w1c_s = 8'h00;
        end

        if (bus.interrupt_ack) begin
            irq_id_d = ack_idx_s;
            if (ack_idx_s == IRQ_ID_NONE) begin
                clr_ack_s = 8'h00;
            end else begin
                clr_ack_s = 8'h01 << ack_idx_s[2:0];
            end
        end else begin
            irq_id_d  = irq_id_q;
            clr_ack_s = 8'h00;
        end

        // New source edges override any clear in the same cycle.
        irq_pend_d  = ((irq_pend_q & ~(clr_w1c_s | clr_ack_s)) |
                       (8'(irq_src) & ~irq_prev_q)) & IRQ_VALID;
        interrupt_d = |irq_masked_s;

        if (wr_s && (ofs_s == OFS_RAM_ADDR)) begin
            ram_addr_d = bus.out_port[RAM_AW-1:0];
        end else if ((wr_s || rd_s) && (ofs_s == OFS_RAM_DATA) && ram_ctrl_q) begin
            ram_addr_d = ram_addr_q + RAM_AW'(1);
        end else begin
            ram_addr_d = ram_addr_q;
        end

        if (wr_s && (ofs_s == OFS_RAM_CTRL)) begin
            ram_ctrl_d = bus.out_port[0];
        end else begin
            ram_ctrl_d = ram_ctrl_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= 8'h00;
            end
            btn_edge_q  <= {NUM_BTN{1'b0}};
            irq_prev_q  <= 8'h00;
            irq_pend_q  <= 8'h00;
            irq_mask_q  <= 8'h00;
            irq_id_q    <= 8'h00;
            interrupt_q <= 1'b0;
            ram_addr_q  <= {RAM_AW{1'b0}};
            ram_ctrl_q  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= out_d[k];
            end
            btn_edge_q  <= btn_edge_d;
            irq_prev_q  <= 8'(irq_src);
            irq_pend_q  <= irq_pend_d;
            irq_mask_q  <= irq_mask_d;
            irq_id_q    <= irq_id_d;
            interrupt_q <= interrupt_d;
            ram_addr_q  <= ram_addr_d;
            ram_ctrl_q  <= ram_ctrl_d;
        end
    end

    // RAM array write port; contents are deliberately not reset.
    always_ff @(posedge pclk) begin
        if (wr_s && (ofs_s == OFS_RAM_DATA)) begin
            mem_q[ram_addr_q] <= bus.out_port;
        end
    end

    // Combinational read mux; zero outside the window and on unused offsets.
    always_comb begin
        rdata_s = 8'h00;
        if (!hit_s) begin
            rdata_s = 8'h00;
        end else if (ofs_s < OFS_IN) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (ofs_s[3:0] == 4'(k)) begin
                    rdata_s = out_q[k];
                end else begin
                    rdata_s = rdata_s;
                end
            end
        end else if (ofs_s < OFS_BTN_LEVEL) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (ofs_s[2:0] == 3'(k)) begin
                    rdata_s = in_regs[8*k +: 8];
                end else begin
                    rdata_s = rdata_s;
                end
            end
        end else begin
            case (ofs_s)
                OFS_BTN_LEVEL: rdata_s = 8'(btn_level_s);
                OFS_BTN_EDGE:  rdata_s = 8'(btn_edge_q);
                OFS_IRQ_MASK:  rdata_s = irq_mask_q;
                OFS_IRQ_PEND:  rdata_s = irq_pend_q;
                OFS_RAM_ADDR:  rdata_s = 8'(ram_addr_q);
                OFS_RAM_DATA:  rdata_s = mem_q[ram_addr_q];
                OFS_RAM_CTRL:  rdata_s = {7'b0000000, ram_ctrl_q};
                OFS_IRQ_ID:    rdata_s = irq_id_q;
                default:       rdata_s = 8'h00;
            endcase
        end
    end

    assign bus.in_port   = rdata_s;
    assign bus.interrupt = interrupt_q;
endmodule

// File: tb/tb_pb_port_hub.sv
// Randomised bench for pb_port_hub against a cycle-level register model.
module tb_pb_port_hub;
    localparam logic [7:0] BASE    = 8'h20;
    localparam int         NUM_OUT = 4;
    localparam int         NUM_IN  = 2;
    localparam int         NUM_BTN = 5;
    localparam int         DB      = 4;
    localparam int         NUM_IRQ = 4;
    localparam int         RAM_AW  = 8;
    localparam int         DEPTH   = 256;

    logic                  pclk = 1'b0;
    logic                  reset;
    logic [NUM_OUT*8-1:0]  out_regs;
    logic [NUM_IN*8-1:0]   in_regs;
    logic [NUM_BTN-1:0]    btn_raw;
    logic [NUM_IRQ-1:0]    irq_src;

    pb_port_hub_if bus();

    pb_port_hub #(
        .BASE(BASE), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .NUM_BTN(NUM_BTN),
        .DB_CYCLES(DB), .NUM_IRQ(NUM_IRQ), .RAM_AW(RAM_AW)
    ) dut (
        .pclk(pclk), .reset(reset), .bus(bus), .out_regs(out_regs),
        .in_regs(in_regs), .btn_raw(btn_raw), .irq_src(irq_src)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0]         m_out [NUM_OUT];
    logic [7:0]         m_ram [DEPTH];
    bit                 m_ram_ok [DEPTH];
    int                 m_addr;
    bit                 m_ctrl;
    logic [7:0]         m_mask, m_pend, m_id, m_btn_lvl, m_btn_edge;
    bit                 m_int;
    logic [NUM_IRQ-1:0] m_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_OUT; k++) m_out[k] = 8'h00;
        m_addr = 0; m_ctrl = 1'b0; m_mask = 8'h00; m_pend = 8'h00; m_id = 8'h00;
        m_btn_lvl = 8'h00; m_btn_edge = 8'h00; m_int = 1'b0; m_prev = '0;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a, output bit known);
        int o;
        known = 1'b1;
        o = int'(a[4:0]);
        if (a[7:5] != BASE[7:5]) return 8'h00;
        if (o < 16) begin
            if (o < NUM_OUT) return m_out[o];
            return 8'h00;
        end
        if (o < 24) begin
            if (o - 16 < NUM_IN) return in_regs[8*(o-16) +: 8];
            return 8'h00;
        end
        case (o)
            24: return m_btn_lvl;
            25: return m_btn_edge;
            26: return m_mask;
            27: return m_pend;
            28: return 8'(m_addr);
            29: begin known = m_ram_ok[m_addr]; return m_ram[m_addr]; end
            30: return {7'b0000000, m_ctrl};
            31: return m_id;
            default: return 8'h00;
        endcase
    endfunction

    // Apply one clock of the model from the currently driven inputs, then
    // advance the DUT by one edge and compare the always-visible outputs.
    task automatic tick();
        bit hit, wr, rd, n_int;
        int o, found;
        logic [7:0] d, clr, rises;
        hit = (bus.port_id[7:5] == BASE[7:5]);
        o   = int'(bus.port_id[4:0]);
        d   = bus.out_port;
        wr  = hit && bus.write_strobe;
        rd  = hit && bus.read_strobe;
        clr = 8'h00;
        rises = 8'h00;
        n_int = ((m_pend & m_mask) != 8'h00);
        if (bus.interrupt_ack) begin
            found = -1;
            for (int i = 0; i < NUM_IRQ; i++)
                if (found < 0 && m_pend[i] && m_mask[i]) found = i;
            if (found < 0) m_id = 8'hFF;
            else begin m_id = 8'(found); clr[found] = 1'b1; end
        end
        if (wr && o == 27) clr = clr | d;
        for (int i = 0; i < NUM_IRQ; i++)
            if (irq_src[i] && !m_prev[i]) rises[i] = 1'b1;
        m_pend = (m_pend & ~clr) | rises;
        m_prev = irq_src;
        if (wr && o == 26) m_mask = d & 8'h0F;
        if (wr && o < NUM_OUT) m_out[o] = d;
        if (wr && o == 28) m_addr = int'(d) % DEPTH;
        if (wr && o == 29) begin m_ram[m_addr] = d; m_ram_ok[m_addr] = 1'b1; end
        if ((wr || rd) && o == 29 && m_ctrl) m_addr = (m_addr + 1) % DEPTH;
        if (wr && o == 30) m_ctrl = d[0];
        if (rd && o == 25) m_btn_edge = 8'h00;
        m_int = n_int;
        @(posedge pclk);
        @(negedge pclk);
        chk("out_regs", out_regs, {m_out[3], m_out[2], m_out[1], m_out[0]});
        chk("interrupt", 32'(bus.interrupt), 32'(m_int));
    endtask

    task automatic bus_op(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] d,
                          input bit ack, input string tag, output logic [7:0] got);
        logic [7:0] e;
        bit known;
        bus.port_id = a; bus.out_port = d;
        bus.write_strobe = wr; bus.read_strobe = rd; bus.interrupt_ack = ack;
        #1;
        got = bus.in_port;
        if (rd) begin
            e = m_read(a, known);
            if (known) chk(tag, got, e);
        end
        tick();
        bus.write_strobe = 1'b0; bus.read_strobe = 1'b0; bus.interrupt_ack = 1'b0;
    endtask

    task automatic w(input logic [4:0] o, input logic [7:0] d);
        logic [7:0] g;
        bus_op(1'b1, 1'b0, BASE | 8'(o), d, 1'b0, "wr", g);
    endtask

    task automatic r(input logic [4:0] o, input string tag, output logic [7:0] g);
        bus_op(1'b0, 1'b1, BASE | 8'(o), 8'h00, 1'b0, tag, g);
    endtask

    task automatic idle();
        logic [7:0] g;
        bus_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "idle", g);
    endtask

    task automatic do_ack();
        logic [7:0] g;
        bus_op(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "ack", g);
    endtask

    task automatic peek(input logic [4:0] o, output logic [7:0] g);
        bus.port_id = BASE | 8'(o);
        #1;
        g = bus.in_port;
    endtask

    initial begin
        logic [7:0] g;
        int rise_at, sel;
        logic [7:0] a;
        reset = 1'b1;
        bus.port_id = 8'h00; bus.out_port = 8'h00;
        bus.write_strobe = 1'b0; bus.read_strobe = 1'b0; bus.interrupt_ack = 1'b0;
        in_regs = 16'hC3A5; btn_raw = '0; irq_src = '0;
        model_reset();
        repeat (2) @(negedge pclk);
        reset = 1'b0;

        // Reset state
        chk("rst_out_regs", out_regs, 32'h0);
        chk("rst_interrupt", 32'(bus.interrupt), 32'h0);
        r(5'h1A, "rst_mask", g); r(5'h1B, "rst_pend", g); r(5'h1C, "rst_addr", g);
        r(5'h1E, "rst_ctrl", g); r(5'h1F, "rst_id", g); r(5'h19, "rst_edge", g);
        r(5'h10, "in0", g); chk("in0_const", g, 8'hA5);

        // Output register write/readback
        w(5'h03, 8'h5A);
        chk("t1_out3", out_regs[31:24], 8'h5A);
        r(5'h03, "t1_rd3", g); chk("t1_rd3_const", g, 8'h5A);
        r(5'h0F, "t1_rd0f", g); chk("t1_rd0f_const", g, 8'h00);

        // Button bounce then stable
        btn_raw[2] = 1'b1; idle();
        btn_raw[2] = 1'b0; idle();
        btn_raw[2] = 1'b1;
        rise_at = 0;
        for (int n = 1; n <= 20; n++) begin
            idle();
            peek(5'h18, g);
            if (g[2] && rise_at == 0) rise_at = n;
        end
        chk("t2_rise_cycle", rise_at, 6);
        m_btn_lvl = 8'h04; m_btn_edge = 8'h04;
        r(5'h18, "t2_level", g);
        r(5'h19, "t2_edge", g); chk("t2_edge_const", g, 8'h04);
        r(5'h19, "t2_edge_again", g); chk("t2_edge_clr", g, 8'h00);
        btn_raw[2] = 1'b0;
        repeat (10) idle();
        m_btn_lvl = 8'h00;
        r(5'h18, "t2_level_fall", g); r(5'h19, "t2_no_fall_edge", g);

        // RAM auto-increment with wrap
        w(5'h1E, 8'h01); w(5'h1C, 8'hFE);
        w(5'h1D, 8'h11); w(5'h1D, 8'h22); w(5'h1D, 8'h33);
        r(5'h1C, "t3_addr", g); chk("t3_addr_const", g, 8'h01);
        w(5'h1E, 8'h00);
        w(5'h1C, 8'hFE); r(5'h1D, "t3_fe", g); chk("t3_fe_const", g, 8'h11);
        w(5'h1C, 8'hFF); r(5'h1D, "t3_ff", g); chk("t3_ff_const", g, 8'h22);
        w(5'h1C, 8'h00); r(5'h1D, "t3_00", g); chk("t3_00_const", g, 8'h33);

        // Prioritised acknowledge
        w(5'h1A, 8'h05);
        irq_src = 4'b0101; idle(); idle();
        chk("t4_int", 32'(bus.interrupt), 32'h1);
        do_ack();
        r(5'h1F, "t4_id0", g); chk("t4_id0_const", g, 8'h00);
        r(5'h1B, "t4_pend", g); chk("t4_pend_const", g, 8'h04);
        chk("t4_int_stays", 32'(bus.interrupt), 32'h1);
        do_ack();
        r(5'h1F, "t4_id2", g); chk("t4_id2_const", g, 8'h02);
        chk("t4_int_drop", 32'(bus.interrupt), 32'h0);
        irq_src = '0;
        do_ack();
        r(5'h1F, "t4_none", g); chk("t4_none_const", g, 8'hFF);

        // Masked pending, unmask, write-one-to-clear
        w(5'h1A, 8'h00);
        irq_src[1] = 1'b1; idle(); idle();
        r(5'h1B, "t5_pend", g); chk("t5_pend_const", g, 8'h02);
        chk("t5_int_masked", 32'(bus.interrupt), 32'h0);
        w(5'h1A, 8'h02); idle();
        chk("t5_int_unmasked", 32'(bus.interrupt), 32'h1);
        w(5'h1B, 8'h02); idle();
        chk("t5_int_w1c", 32'(bus.interrupt), 32'h0);
        irq_src = '0;

        // Random register traffic against the model
        for (int it = 0; it < 500; it++) begin
            irq_src = 4'($urandom);
            in_regs = 16'($urandom);
            sel = $urandom_range(0, 9);
            a = BASE | 8'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            if (sel <= 2) bus_op(1'b1, 1'b0, a, 8'($urandom), 1'b0, "rand_wr", g);
            else if (sel <= 6) bus_op(1'b0, 1'b1, a, 8'h00, 1'b0, "rand_rd", g);
            else if (sel == 7) bus_op(1'b0, 1'b0, a, 8'h00, 1'b1, "rand_ack", g);
            else if (sel == 8) bus_op(1'b1, 1'b0, BASE | 8'h1A, 8'($urandom), 1'b0, "rand_mask", g);
            else bus_op(1'b0, 1'b1, BASE | 8'h1D, 8'h00, 1'b0, "rand_ram", g);
        end
        irq_src = '0;
        idle();

        // Reset with edge, pending IRQ and a debounce in progress
        btn_raw[0] = 1'b1;
        repeat (8) idle();
        m_btn_lvl = 8'h01; m_btn_edge = 8'h01;
        w(5'h1A, 8'h0F);
        irq_src = 4'b1000; idle(); irq_src = '0; idle();
        w(5'h00, 8'hAB);
        chk("t6_int_pre", 32'(bus.interrupt), 32'h1);
        btn_raw[3] = 1'b1;
        repeat (4) idle();
        reset = 1'b1;
        #1;
        chk("t6_out_regs", out_regs, 32'h0);
        chk("t6_interrupt", 32'(bus.interrupt), 32'h0);
        peek(5'h19, g); chk("t6_edge", g, 8'h00);
        peek(5'h1B, g); chk("t6_pend", g, 8'h00);
        peek(5'h18, g); chk("t6_level", g, 8'h00);
        btn_raw[0] = 1'b0;
        model_reset();
        repeat (2) @(negedge pclk);
        reset = 1'b0;
        repeat (2) idle();
        btn_raw[3] = 1'b0;
        repeat (10) idle();
        r(5'h18, "t6_level_after", g); chk("t6_level_after_const", g, 8'h00);
        r(5'h19, "t6_edge_after", g); chk("t6_edge_after_const", g, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
